controle_irrigacao: RTL and testbench

Irrigation cycle controller that sits directly downstream of the seconds counter chain. It consumes the one-cycle carry pulse of the 0–9 counter as a 1 s tick, together with soil-moisture and reservoir-level sensors. It sequences pump priming, watering and soak phases and drives the pump, valve and alarm. Remaining phase time is exposed as two BCD digits for the display stage.

---
 rtl/controle_irrigacao.sv | 241 ++++++++++++++++++++++++
 tb/tb_controle_irrigacao.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_irrigacao.sv
`default_nettype none
// ============================================================================
// Module      : controle_irrigacao
// Description : Irrigation cycle controller. Sequences pump priming, watering
//               and soak phases from a 1 s tick, soil-moisture and reservoir
//               sensors, and drives pump, valve and alarm. Remaining phase
//               time is exposed as two BCD digits for the display stage.
// Ports       : clock          - system clock, rising edge
//               reset          - asynchronous, active-low reset
//               tick           - one-clock pulse per second (same clock domain)
//               umidade_baixa  - soil dry (1 = needs water), asynchronous
//               nivel_ok       - reservoir level sufficient, asynchronous
//               manual_start   - operator start button (level), asynchronous
//               parada         - operator stop (level), asynchronous
//               bomba          - pump enable
//               valvula        - valve open
//               alarme         - fault indicator
//               estado         - state code (0 idle .. 4 fault)
//               tempo_dez      - remaining phase time, BCD tens
//               tempo_unid     - remaining phase time, BCD units
//               ciclo_fim      - one-clock pulse at end of watering
// Revision    : 1.0 - initial release
// ============================================================================
module controle_irrigacao #(
   parameter int TEMPO_PRE    = 3,
   parameter int TEMPO_REGA   = 45,
   parameter int TEMPO_ESPERA = 30,
   parameter int MAX_CICLOS   = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick,
   input  logic       umidade_baixa,
   input  logic       nivel_ok,
   input  logic       manual_start,
   input  logic       parada,
   output logic       bomba,
   output logic       valvula,
   output logic       alarme,
   output logic [2:0] estado,
   output logic [3:0] tempo_dez,
   output logic [3:0] tempo_unid,
   output logic       ciclo_fim
);

   localparam logic [2:0] c_ocioso  = 3'd0;
   localparam logic [2:0] c_preparo = 3'd1;
   localparam logic [2:0] c_regando = 3'd2;
   localparam logic [2:0] c_espera  = 3'd3;
   localparam logic [2:0] c_falha   = 3'd4;

   // Phase durations pre-converted to BCD so the timer reloads directly.
   localparam logic [7:0] c_carga_pre    = {4'(TEMPO_PRE / 10),    4'(TEMPO_PRE % 10)};
   localparam logic [7:0] c_carga_rega   = {4'(TEMPO_REGA / 10),   4'(TEMPO_REGA % 10)};
   localparam logic [7:0] c_carga_espera = {4'(TEMPO_ESPERA / 10), 4'(TEMPO_ESPERA % 10)};
   localparam logic [2:0] c_max_ciclos   = 3'(MAX_CICLOS);

   // Two-stage synchronizers; bit [1] is the usable synchronized value.
   logic [1:0] r_umid_sync;
   logic [1:0] r_nivel_sync;
   logic [1:0] r_start_sync;
   logic [1:0] r_parada_sync;
   logic       r_start_prev;

   logic [2:0] r_estado;
   logic [7:0] r_tempo;
   logic [2:0] r_ciclos;
   logic       r_bomba;
   logic       r_valvula;
   logic       r_alarme;
   logic       r_ciclo_fim;

   logic       w_umid;
   logic       w_nivel;
   logic       w_parada;
   logic       w_start_rise;
   logic       w_tempo_fim;
   logic [7:0] w_tempo_dec;
   logic [2:0] w_prox_estado;
   logic [7:0] w_prox_tempo;
   logic [2:0] w_prox_ciclos;
   logic       w_prox_fim;
   logic       w_bomba;
   logic       w_valvula;
   logic       w_alarme;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_umid_sync   <= 2'b00;
         r_nivel_sync  <= 2'b00;
         r_start_sync  <= 2'b00;
         r_parada_sync <= 2'b00;
         r_start_prev  <= 1'b0;
      end else begin
         r_umid_sync   <= {r_umid_sync[0],   umidade_baixa};
         r_nivel_sync  <= {r_nivel_sync[0],  nivel_ok};
         r_start_sync  <= {r_start_sync[0],  manual_start};
         r_parada_sync <= {r_parada_sync[0], parada};
         r_start_prev  <= r_start_sync[1];
      end
   end

   assign w_umid       = r_umid_sync[1];
   assign w_nivel      = r_nivel_sync[1];
   assign w_parada     = r_parada_sync[1];
   assign w_start_rise = r_start_sync[1] & ~r_start_prev;

   // A tick at 01 ends the phase, so each phase spans exactly its parameter.
   assign w_tempo_fim = (r_tempo == 8'h01);
   assign w_tempo_dec = (r_tempo[3:0] == 4'd0) ? {r_tempo[7:4] - 4'd1, 4'd9}
                                               : {r_tempo[7:4], r_tempo[3:0] - 4'd1};

   // State register: every output is registered from the next-state decode.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_estado    <= c_ocioso;
         r_tempo     <= 8'h00;
         r_ciclos    <= 3'd0;
         r_bomba     <= 1'b0;
         r_valvula   <= 1'b0;
         r_alarme    <= 1'b0;
         r_ciclo_fim <= 1'b0;
      end else begin
         r_estado    <= w_prox_estado;
         r_tempo     <= w_prox_tempo;
         r_ciclos    <= w_prox_ciclos;
         r_bomba     <= w_bomba;
         r_valvula   <= w_valvula;
         r_alarme    <= w_alarme;
         r_ciclo_fim <= w_prox_fim;
      end
   end

   // Next-state logic. Branch order encodes the edge priority:
   // stop, then level fault, then timer expiry, then start request.
   always_comb begin
      w_prox_estado = r_estado;
      w_prox_tempo  = r_tempo;
      w_prox_ciclos = r_ciclos;
      w_prox_fim    = 1'b0;
      case (r_estado)
         c_ocioso: begin
            w_prox_tempo  = 8'h00;
            w_prox_ciclos = 3'd0;
            if (!w_parada) begin
               if (w_nivel && (w_umid || w_start_rise)) begin
                  w_prox_estado = c_preparo;
                  w_prox_tempo  = c_carga_pre;
               end else if (!w_nivel && w_start_rise) begin
                  w_prox_estado = c_falha;
               end
            end
         end
         c_preparo, c_regando: begin
            if (w_parada) begin
               w_prox_estado = c_ocioso;
               w_prox_tempo  = 8'h00;
               w_prox_ciclos = 3'd0;
            end else if (!w_nivel) begin
               w_prox_estado = c_falha;
               w_prox_tempo  = 8'h00;
            end else if (tick) begin
               if (w_tempo_fim) begin
                  if (r_estado == c_preparo) begin
                     w_prox_estado = c_regando;
                     w_prox_tempo  = c_carga_rega;
                  end else begin
                     w_prox_estado = c_espera;
                     w_prox_tempo  = c_carga_espera;
                     w_prox_fim    = 1'b1;
                     w_prox_ciclos = r_ciclos + 3'd1;
                  end
               end else begin
                  w_prox_tempo = w_tempo_dec;
               end
            end
         end
         c_espera: begin
            if (w_parada) begin
               w_prox_estado = c_ocioso;
               w_prox_tempo  = 8'h00;
               w_prox_ciclos = 3'd0;
            end else if (tick) begin
               if (w_tempo_fim) begin
                  if (!w_umid) begin
                     w_prox_estado = c_ocioso;
                     w_prox_tempo  = 8'h00;
                     w_prox_ciclos = 3'd0;
                  end else if (r_ciclos < c_max_ciclos) begin
                     w_prox_estado = c_preparo;
                     w_prox_tempo  = c_carga_pre;
                  end else begin
                     w_prox_estado = c_falha;
                     w_prox_tempo  = 8'h00;
                  end
               end else begin
                  w_prox_tempo = w_tempo_dec;
               end
            end
         end
         c_falha: begin
            w_prox_tempo = 8'h00;
            if (w_parada && w_nivel) begin
               w_prox_estado = c_ocioso;
               w_prox_ciclos = 3'd0;
            end
         end
         default: begin
            w_prox_estado = c_ocioso;
            w_prox_tempo  = 8'h00;
            w_prox_ciclos = 3'd0;
         end
      endcase
   end

   // Output decode from the next state so actuators change on the same edge.
   always_comb begin
      w_bomba   = 1'b0;
      w_valvula = 1'b0;
      w_alarme  = 1'b0;
      case (w_prox_estado)
         c_preparo: w_bomba = 1'b1;
         c_regando: begin
            w_bomba   = 1'b1;
            w_valvula = 1'b1;
         end
         c_falha:   w_alarme = 1'b1;
         default:   ;
      endcase
   end

   assign bomba      = r_bomba;
   assign valvula    = r_valvula;
   assign alarme     = r_alarme;
   assign estado     = r_estado;
   assign tempo_dez  = r_tempo[7:4];
   assign tempo_unid = r_tempo[3:0];
   assign ciclo_fim  = r_ciclo_fim;

endmodule
`default_nettype wire

// File: tb/tb_controle_irrigacao.sv
`default_nettype none
// ============================================================================
// Module      : tb_controle_irrigacao
// Description : Self-checking bench for controle_irrigacao. A behavioural
//               model (phase + remaining seconds as integers, inputs delayed
//               by the synchronizer latency) is compared against the DUT on
//               every cycle; directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_irrigacao;

   localparam int P_PRE  = 2;
   localparam int P_REGA = 12;
   localparam int P_ESP  = 3;
   localparam int P_MAX  = 2;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       tick = 1'b0;
   logic       umid = 1'b0;
   logic       niv = 1'b0;
   logic       mst = 1'b0;
   logic       par = 1'b0;
   logic       bomba;
   logic       valvula;
   logic       alarme;
   logic [2:0] estado;
   logic [3:0] tempo_dez;
   logic [3:0] tempo_unid;
   logic       ciclo_fim;

   controle_irrigacao #(
      .TEMPO_PRE    (P_PRE),
      .TEMPO_REGA   (P_REGA),
      .TEMPO_ESPERA (P_ESP),
      .MAX_CICLOS   (P_MAX)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .tick          (tick),
      .umidade_baixa (umid),
      .nivel_ok      (niv),
      .manual_start  (mst),
      .parada        (par),
      .bomba         (bomba),
      .valvula       (valvula),
      .alarme        (alarme),
      .estado        (estado),
      .tempo_dez     (tempo_dez),
      .tempo_unid    (tempo_unid),
      .ciclo_fim     (ciclo_fim)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;
   int n_cf    = 0;

   // Model: phase (0 idle,1 priming,2 watering,3 soak,4 fault), seconds left.
   int m_fase = 0;
   int m_rest = 0;
   int m_cnt  = 0;
   bit m_cf   = 1'b0;
   // Input history: index k = value presented before the edge k cycles ago.
   bit h_u[4];
   bit h_n[4];
   bit h_s[4];
   bit h_p[4];

   task automatic lit(input string nome, input logic [15:0] atual, input logic [15:0] esperado);
      n_tests++;
      if (atual !== esperado) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clock) begin
      logic [14:0] exp_v;
      logic [14:0] act_v;
      exp_v = {(m_fase == 1 || m_fase == 2), (m_fase == 2), (m_fase == 4),
               3'(m_fase), 4'(m_rest / 10), 4'(m_rest % 10), m_cf};
      act_v = {bomba, valvula, alarme, estado, tempo_dez, tempo_unid, ciclo_fim};
      n_tests++;
      if (act_v !== exp_v) begin
         n_fail++;
         $display("FAIL model_cmp t=%0t: got %0h expected %0h (b,v,a,est,dez,uni,fim)",
                  $time, act_v, exp_v);
      end
      if (ciclo_fim === 1'b1) n_cf++;
   end

   task automatic model_reset();
      m_fase = 0;
      m_rest = 0;
      m_cnt  = 0;
      m_cf   = 1'b0;
      for (int k = 0; k < 4; k++) begin
         h_u[k] = 1'b0;
         h_n[k] = 1'b0;
         h_s[k] = 1'b0;
         h_p[k] = 1'b0;
      end
   endtask

   // One model step for the upcoming rising edge.
   task automatic passo(input bit t);
      bit u, n, p, rise;
      u    = h_u[2];
      n    = h_n[2];
      p    = h_p[2];
      rise = h_s[2] && !h_s[3];
      m_cf = 1'b0;
      case (m_fase)
         0: begin
            if (!p) begin
               if (n && (u || rise)) begin
                  m_fase = 1;
                  m_rest = P_PRE;
               end else if (!n && rise) begin
                  m_fase = 4;
               end
            end
         end
         1, 2: begin
            if (p) begin
               m_fase = 0; m_rest = 0; m_cnt = 0;
            end else if (!n) begin
               m_fase = 4; m_rest = 0;
            end else if (t) begin
               if (m_rest == 1) begin
                  if (m_fase == 1) begin
                     m_fase = 2; m_rest = P_REGA;
                  end else begin
                     m_fase = 3; m_rest = P_ESP; m_cf = 1'b1; m_cnt++;
                  end
               end else begin
                  m_rest--;
               end
            end
         end
         3: begin
            if (p) begin
               m_fase = 0; m_rest = 0; m_cnt = 0;
            end else if (t) begin
               if (m_rest == 1) begin
                  if (!u) begin
                     m_fase = 0; m_rest = 0; m_cnt = 0;
                  end else if (m_cnt < P_MAX) begin
                     m_fase = 1; m_rest = P_PRE;
                  end else begin
                     m_fase = 4; m_rest = 0;
                  end
               end else begin
                  m_rest--;
               end
            end
         end
         default: begin
            if (p && n) begin
               m_fase = 0; m_cnt = 0;
            end
         end
      endcase
   endtask

   task automatic ciclo(input bit t, input bit u, input bit n, input bit s, input bit p, input bit r);
      @(negedge clock);
      #1;
      tick = t; umid = u; niv = n; mst = s; par = p; reset = r;
      if (!r) begin
         model_reset();
      end else begin
         for (int k = 3; k > 0; k--) begin
            h_u[k] = h_u[k-1]; h_n[k] = h_n[k-1];
            h_s[k] = h_s[k-1]; h_p[k] = h_p[k-1];
         end
         h_u[0] = u; h_n[0] = n; h_s[0] = s; h_p[0] = p;
         passo(t);
      end
   endtask

   task automatic runt(input int k, input bit u, input bit n, input bit s, input bit p);
      repeat (k) begin
         ciclo(1'b1, u, n, s, p, 1'b1);
         ciclo(1'b0, u, n, s, p, 1'b1);
      end
   endtask

   task automatic async_rst();
      @(negedge clock);
      #2;
      reset = 1'b0;
      #1;
      lit("rst_async_bomba", 16'(bomba), 16'd0);
      lit("rst_async_estado", 16'(estado), 16'd0);
      model_reset();
   endtask

   task automatic amostra();
      @(posedge clock);
      #1;
   endtask

   logic [7:0] seq_rega [12] = '{8'h12, 8'h11, 8'h10, 8'h09, 8'h08, 8'h07,
                                 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};

   initial begin
      int cf_base;
      bit ru, rn, rs, rp, rt;
      model_reset();

      // Reset state
      repeat (3) ciclo(0, 0, 0, 0, 0, 0);
      amostra();
      lit("reset_estado", 16'(estado), 16'd0);
      lit("reset_timer", {8'h00, tempo_dez, tempo_unid}, 16'h0000);
      lit("reset_saidas", {13'd0, bomba, valvula, alarme}, 16'd0);
      repeat (3) ciclo(0, 0, 1, 0, 0, 1);

      // Dry soil starts a cycle; watering timer counts 12..01 with borrow
      repeat (3) ciclo(0, 1, 1, 0, 0, 1);
      amostra();
      lit("preparo_estado", 16'(estado), 16'd1);
      lit("preparo_bomba", 16'(bomba), 16'd1);
      lit("preparo_timer", {8'h00, tempo_dez, tempo_unid}, 16'h0002);
      runt(2, 1, 1, 0, 0);
      for (int i = 0; i < 12; i++) begin
         ciclo(0, (i < 6), 1, 0, 0, 1);
         amostra();
         lit("timer_rega", {8'h00, tempo_dez, tempo_unid}, {8'h00, seq_rega[i]});
         if (i == 0) lit("rega_valvula", 16'(valvula), 16'd1);
         ciclo(1, (i < 6), 1, 0, 0, 1);
      end
      amostra();
      lit("fim_rega_estado", 16'(estado), 16'd3);
      lit("fim_rega_pulso", 16'(ciclo_fim), 16'd1);
      runt(3, 0, 1, 0, 0);
      amostra();
      lit("espera_fim_ocioso", 16'(estado), 16'd0);
      lit("espera_fim_timer", {8'h00, tempo_dez, tempo_unid}, 16'h0000);
      runt(3, 0, 1, 0, 0);
      amostra();
      lit("tick_ocioso_timer", {8'h00, tempo_dez, tempo_unid}, 16'h0000);

      // Soil stays dry: two cycles then fault
      cf_base = n_cf;
      repeat (3) ciclo(0, 1, 1, 0, 0, 1);
      runt(40, 1, 1, 0, 0);
      amostra();
      lit("max_ciclos_pulsos", 16'(n_cf - cf_base), 16'd2);
      lit("max_ciclos_estado", 16'(estado), 16'd4);
      lit("max_ciclos_saidas", {13'd0, bomba, valvula, alarme}, 16'b001);
      repeat (3) ciclo(0, 1, 1, 0, 1, 1);
      amostra();
      lit("falha_limpa_estado", 16'(estado), 16'd0);
      lit("falha_limpa_alarme", 16'(alarme), 16'd0);

      // Level drop together with a tick while watering
      repeat (4) ciclo(0, 1, 1, 0, 0, 1);
      runt(3, 1, 1, 0, 0);
      amostra();
      lit("nivel_pre_estado", 16'(estado), 16'd2);
      ciclo(0, 1, 0, 0, 0, 1);
      ciclo(0, 1, 0, 0, 0, 1);
      ciclo(1, 1, 0, 0, 0, 1);
      amostra();
      lit("nivel_falha_estado", 16'(estado), 16'd4);
      lit("nivel_falha_saidas", {13'd0, bomba, valvula, alarme}, 16'b001);
      lit("nivel_falha_timer", {8'h00, tempo_dez, tempo_unid}, 16'h0000);
      repeat (3) ciclo(0, 0, 1, 0, 1, 1);
      amostra();
      lit("nivel_rec_alarme", 16'(alarme), 16'd0);

      // Stop during watering; held start must not restart
      repeat (3) ciclo(0, 0, 1, 0, 0, 1);
      ciclo(0, 0, 1, 1, 0, 1);
      repeat (2) ciclo(0, 0, 1, 0, 0, 1);
      amostra();
      lit("manual_preparo", 16'(estado), 16'd1);
      runt(3, 0, 1, 0, 0);
      ciclo(0, 0, 1, 1, 1, 1);
      repeat (2) ciclo(0, 0, 1, 1, 0, 1);
      amostra();
      lit("parada_estado", 16'(estado), 16'd0);
      lit("parada_timer", {8'h00, tempo_dez, tempo_unid}, 16'h0000);
      repeat (6) ciclo(0, 0, 1, 1, 0, 1);
      amostra();
      lit("start_preso", 16'(estado), 16'd0);
      repeat (3) ciclo(0, 0, 1, 0, 0, 1);
      repeat (3) ciclo(0, 0, 1, 1, 0, 1);
      amostra();
      lit("start_novo", 16'(estado), 16'd1);

      // Asynchronous reset mid-priming, dry soil restarts at the 3rd edge
      ciclo(0, 1, 1, 0, 0, 1);
      async_rst();
      repeat (2) ciclo(0, 1, 1, 0, 0, 0);
      ciclo(0, 1, 1, 0, 0, 1);
      amostra();
      lit("pos_rst_borda1", 16'(estado), 16'd0);
      ciclo(0, 1, 1, 0, 0, 1);
      amostra();
      lit("pos_rst_borda2", 16'(estado), 16'd0);
      ciclo(0, 1, 1, 0, 0, 1);
      amostra();
      lit("pos_rst_borda3", 16'(estado), 16'd1);

      // Randomized traffic against the model
      ru = 1'b1; rn = 1'b1; rs = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 699) == 0) begin
            async_rst();
            ciclo(0, ru, rn, rs, 0, 0);
         end else begin
            if ($urandom_range(0, 39) == 0) ru = ~ru;
            if ($urandom_range(0, 59) == 0) rn = ~rn;
            if ($urandom_range(0, 7) == 0) rs = ~rs;
            rp = ($urandom_range(0, 59) == 0);
            rt = ($urandom_range(0, 2) == 0);
            ciclo(rt, ru, rn, rs, rp, 1);
         end
      end
      repeat (3) ciclo(0, 0, 1, 0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
